// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared constants and types for the SHA-256 compression engine:
//   K      - the 64 round constants, indexed by round number
//   IV     - the standard initial hash value, packed so index 0 = a (H0)
//   state_e- engine FSM states
//   unroll_legal() - which rounds-per-clock settings the engine supports
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Concatenation lists h first because the highest packed index (h) is the MSB.
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  // 64 rounds must split evenly into steps, and the schedule window (16 words)
  // must cover all words consumed in one step.
  function automatic bit unroll_legal(input int unroll);
    return (unroll == 1) || (unroll == 2) || (unroll == 4) || (unroll == 8);
  endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// sha256_compress_if
// Request/response bundle between the block formatter (master) and the
// compression engine (slave).
//   i_valid/o_ready  : request handshake; i_block, i_state, i_use_iv qualify it
//   o_valid/i_ready  : response handshake; o_state qualifies it
//   o_busy           : engine is computing (ROUND or FINAL)
// Handshake rule (both directions): a transfer happens on a rising clock edge
// where valid and ready are both high. The sender keeps valid and its data
// steady until that edge; ready carries no obligation and may be low for any
// number of cycles.
interface sha256_compress_if;
  logic             i_valid;
  logic             o_ready;
  logic [15:0][31:0] i_block;
  logic [7:0][31:0]  i_state;
  logic             i_use_iv;
  logic [7:0][31:0]  o_state;
  logic             o_valid;
  logic             i_ready;
  logic             o_busy;

  modport master (
    output i_valid, i_block, i_state, i_use_iv, i_ready,
    input  o_ready, o_state, o_valid, o_busy
  );

  modport slave (
    input  i_valid, i_block, i_state, i_use_iv, i_ready,
    output o_ready, o_state, o_valid, o_busy
  );
endinterface

// File: rtl/choose.sv
// choose: Ch(e,f,g) -- per bit, e selects f (1) or g (0).
//   e_i, f_i, g_i : input words   y_o : result
module choose (
  input  logic [31:0] e_i,
  input  logic [31:0] f_i,
  input  logic [31:0] g_i,
  output logic [31:0] y_o
);
  assign y_o = (e_i & f_i) ^ (~e_i & g_i);
endmodule

// File: rtl/majority.sv
// majority: Maj(a,b,c) -- per bit majority vote.
//   a_i, b_i, c_i : input words   y_o : result
module majority (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  output logic [31:0] y_o
);
  assign y_o = (a_i & b_i) ^ (a_i & c_i) ^ (b_i & c_i);
endmodule

// File: rtl/sha256_round.sv
// sha256_round
// One combinational SHA-256 round.
//   letters_i : working letters, index 0 = a ... index 7 = h
//   w_i       : schedule word W[t]
//   k_i       : round constant K[t]
//   letters_o : letters after the round, same ordering
module sha256_round (
  input  logic [7:0][31:0] letters_i,
  input  logic [31:0]      w_i,
  input  logic [31:0]      k_i,
  output logic [7:0][31:0] letters_o
);
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] big_s0, big_s1, ch, maj, t1, t2;

  assign a = letters_i[0];
  assign b = letters_i[1];
  assign c = letters_i[2];
  assign d = letters_i[3];
  assign e = letters_i[4];
  assign f = letters_i[5];
  assign g = letters_i[6];
  assign h = letters_i[7];

  sigma_0  u_big_s0 (.x_i(a), .y_o(big_s0));
  sigma_1  u_big_s1 (.x_i(e), .y_o(big_s1));
  choose   u_ch     (.e_i(e), .f_i(f), .g_i(g), .y_o(ch));
  majority u_maj    (.a_i(a), .b_i(b), .c_i(c), .y_o(maj));

  assign t1 = h + big_s1 + ch + k_i + w_i;
  assign t2 = big_s0 + maj;

  // MSB-first concatenation: h' = g ... e' = d + T1 ... a' = T1 + T2.
  assign letters_o = {g, f, e, d + t1, c, b, a, t1 + t2};
endmodule

// File: rtl/sigma_0.sv
// sigma_0: SHA-256 big Sigma0, ROTR2 ^ ROTR13 ^ ROTR22.
//   x_i : input word   y_o : result
module sigma_0 (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);
  assign y_o = {x_i[1:0], x_i[31:2]} ^ {x_i[12:0], x_i[31:13]} ^ {x_i[21:0], x_i[31:22]};
endmodule

// File: rtl/sigma_1.sv
// sigma_1: SHA-256 big Sigma1, ROTR6 ^ ROTR11 ^ ROTR25.
//   x_i : input word   y_o : result
module sigma_1 (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);
  assign y_o = {x_i[5:0], x_i[31:6]} ^ {x_i[10:0], x_i[31:11]} ^ {x_i[24:0], x_i[31:25]};
endmodule

// File: rtl/sigma_shift_0.sv
// sigma_shift_0: SHA-256 schedule sigma0, ROTR7 ^ ROTR18 ^ SHR3.
//   x_i : input word   y_o : result
module sigma_shift_0 (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);
  assign y_o = {x_i[6:0], x_i[31:7]} ^ {x_i[17:0], x_i[31:18]} ^ (x_i >> 3);
endmodule

// File: rtl/sigma_shift_1.sv
// sigma_shift_1: SHA-256 schedule sigma1, ROTR17 ^ ROTR19 ^ SHR10.
//   x_i : input word   y_o : result
module sigma_shift_1 (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);
  assign y_o = {x_i[16:0], x_i[31:17]} ^ {x_i[18:0], x_i[31:19]} ^ (x_i >> 10);
endmodule

// File: rtl/sha256_compress.sv
// sha256_compress
// Iterative SHA-256 compression: UNROLL rounds per clock, on-chip message
// schedule, final feed-forward add.
//   clk, rst     : clock; synchronous active-high reset
//   bus (slave)  : request (i_valid/o_ready, i_block, i_state, i_use_iv),
//                  response (o_valid/i_ready, o_state), o_busy
//   o_dbg_state  : current FSM state
// Parameters: UNROLL (1/2/4/8 rounds per clock), OUT_HOLD (1 = keep digest
// after the response handshake, 0 = clear it).
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int UNROLL   = 1,
  parameter bit OUT_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  sha256_compress_if.slave  bus,
  output state_e            o_dbg_state
);

  if (!unroll_legal(UNROLL)) begin : g_bad_unroll
    $error("sha256_compress: UNROLL must be 1, 2, 4 or 8");
  end

  state_e            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [7:0][31:0]  letters_q, letters_d;
  logic [7:0][31:0]  ff_q, ff_d;
  logic [7:0][31:0]  out_q, out_d;
  logic [15:0][31:0] w_q, w_d;
  logic              valid_q, valid_d;

  logic [7:0][31:0]  init_state;
  logic [7:0][31:0]  letters_rnd;
  logic [15:0][31:0] w_shift;

  assign init_state = bus.i_use_iv ? IV : bus.i_state;

  // Round chain: window word j is W[cnt + j] for this step, so the rounds
  // never need a word produced in the same cycle.
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    logic [7:0][31:0] l_in;
    logic [7:0][31:0] l_out;
    logic [5:0]       k_idx;

    assign k_idx = cnt_q[5:0] + 6'(j);

    if (j == 0) begin : g_first
      assign l_in = letters_q;
    end else begin : g_chain
      assign l_in = g_rnd[j-1].l_out;
    end

    sha256_round u_round (
      .letters_i (l_in),
      .w_i       (w_q[j]),
      .k_i       (K[k_idx]),
      .letters_o (l_out)
    );
  end

  assign letters_rnd = g_rnd[UNROLL-1].l_out;

  // Schedule expansion: new word j is W[cnt + 16 + j]. Its W[-2] and W[-7]
  // taps fall on words created earlier in this same step once j >= 2 / j >= 7,
  // so those taps come from the earlier expansion slices.
  for (genvar j = 0; j < UNROLL; j++) begin : g_sch
    logic [31:0] w_m2, w_m7, s0, s1, w_new;

    if (j >= 2) begin : g_m2_new
      assign w_m2 = g_sch[j-2].w_new;
    end else begin : g_m2_old
      assign w_m2 = w_q[14+j];
    end

    if (j >= 7) begin : g_m7_new
      assign w_m7 = g_sch[j-7].w_new;
    end else begin : g_m7_old
      assign w_m7 = w_q[9+j];
    end

    sigma_shift_0 u_s0 (.x_i(w_q[1+j]), .y_o(s0));
    sigma_shift_1 u_s1 (.x_i(w_m2),     .y_o(s1));

    assign w_new = s1 + w_m7 + s0 + w_q[j];
  end

  // Window after the step: drop the UNROLL consumed words, append new ones.
  for (genvar i = 0; i < 16; i++) begin : g_shift
    if (i + UNROLL < 16) begin : g_keep
      assign w_shift[i] = w_q[i+UNROLL];
    end else begin : g_append
      assign w_shift[i] = g_sch[i+UNROLL-16].w_new;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    letters_d = letters_q;
    ff_d      = ff_q;
    out_d     = out_q;
    w_d       = w_q;
    valid_d   = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          letters_d = init_state;
          ff_d      = init_state;
          w_d       = bus.i_block;
          cnt_d     = '0;
          state_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        letters_d = letters_rnd;
        w_d       = w_shift;
        cnt_d     = cnt_q + 7'(UNROLL);
        if (cnt_q == 7'(64 - UNROLL)) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        for (int i = 0; i < 8; i++) begin
          out_d[i] = ff_q[i] + letters_q[i];
        end
        valid_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.i_ready) begin
          valid_d = 1'b0;
          if (!OUT_HOLD) begin
            out_d = '0;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      letters_q <= '0;
      ff_q      <= '0;
      out_q     <= '0;
      w_q       <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      letters_q <= letters_d;
      ff_q      <= ff_d;
      out_q     <= out_d;
      w_q       <= w_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.o_ready  = (state_q == ST_IDLE);
  assign bus.o_busy   = (state_q == ST_ROUND) || (state_q == ST_FINAL);
  assign bus.o_valid  = valid_q;
  assign bus.o_state  = out_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Bench for sha256_compress: four engines (UNROLL 1/2/4/8, the UNROLL=4 one
// with OUT_HOLD=0) share one stimulus set; sel picks which engine sees the
// handshakes and whose outputs are observed.
module tb_sha256_compress;
  import sha256_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus / muxed observation ----------------
  int                sel;
  logic              i_valid, i_use_iv, i_ready;
  logic [15:0][31:0] i_block;
  logic [7:0][31:0]  i_state;
  logic              o_ready, o_valid, o_busy;
  logic [7:0][31:0]  o_state;
  state_e            dbg_state;

  sha256_compress_if bus_u1 ();
  sha256_compress_if bus_u2 ();
  sha256_compress_if bus_u4 ();
  sha256_compress_if bus_u8 ();
  state_e dbg_u1, dbg_u2, dbg_u4, dbg_u8;

  assign bus_u1.i_valid = i_valid && (sel == 0);
  assign bus_u2.i_valid = i_valid && (sel == 1);
  assign bus_u4.i_valid = i_valid && (sel == 2);
  assign bus_u8.i_valid = i_valid && (sel == 3);
  assign bus_u1.i_ready = i_ready && (sel == 0);
  assign bus_u2.i_ready = i_ready && (sel == 1);
  assign bus_u4.i_ready = i_ready && (sel == 2);
  assign bus_u8.i_ready = i_ready && (sel == 3);
  assign bus_u1.i_block = i_block;  assign bus_u1.i_state = i_state;  assign bus_u1.i_use_iv = i_use_iv;
  assign bus_u2.i_block = i_block;  assign bus_u2.i_state = i_state;  assign bus_u2.i_use_iv = i_use_iv;
  assign bus_u4.i_block = i_block;  assign bus_u4.i_state = i_state;  assign bus_u4.i_use_iv = i_use_iv;
  assign bus_u8.i_block = i_block;  assign bus_u8.i_state = i_state;  assign bus_u8.i_use_iv = i_use_iv;

  sha256_compress #(.UNROLL(1), .OUT_HOLD(1'b1)) dut_u1 (.clk(clk), .rst(rst), .bus(bus_u1), .o_dbg_state(dbg_u1));
  sha256_compress #(.UNROLL(2), .OUT_HOLD(1'b1)) dut_u2 (.clk(clk), .rst(rst), .bus(bus_u2), .o_dbg_state(dbg_u2));
  sha256_compress #(.UNROLL(4), .OUT_HOLD(1'b0)) dut_u4 (.clk(clk), .rst(rst), .bus(bus_u4), .o_dbg_state(dbg_u4));
  sha256_compress #(.UNROLL(8), .OUT_HOLD(1'b1)) dut_u8 (.clk(clk), .rst(rst), .bus(bus_u8), .o_dbg_state(dbg_u8));

  always_comb begin
    o_ready = bus_u1.o_ready; o_valid = bus_u1.o_valid; o_busy = bus_u1.o_busy;
    o_state = bus_u1.o_state; dbg_state = dbg_u1;
    case (sel)
      1: begin o_ready = bus_u2.o_ready; o_valid = bus_u2.o_valid; o_busy = bus_u2.o_busy;
               o_state = bus_u2.o_state; dbg_state = dbg_u2; end
      2: begin o_ready = bus_u4.o_ready; o_valid = bus_u4.o_valid; o_busy = bus_u4.o_busy;
               o_state = bus_u4.o_state; dbg_state = dbg_u4; end
      3: begin o_ready = bus_u8.o_ready; o_valid = bus_u8.o_valid; o_busy = bus_u8.o_busy;
               o_state = bus_u8.o_state; dbg_state = dbg_u8; end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [255:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference vectors written MSB-first (W0 / H0 leftmost) and converted to
  // the index-0-first packing the engine uses.
  function automatic logic [15:0][31:0] blk_be(input logic [511:0] m);
    logic [15:0][31:0] r;
    for (int i = 0; i < 16; i++) r[i] = m[511-32*i -: 32];
    return r;
  endfunction

  function automatic logic [7:0][31:0] dig_be(input logic [255:0] d);
    logic [7:0][31:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[255-32*i -: 32];
    return r;
  endfunction

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_MID   = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < 16; i++) i_block[i] = $urandom;
    for (int i = 0; i < 8; i++)  i_state[i] = $urandom;
    i_use_iv = 1'($urandom_range(0, 1));
  endtask

  // Presents a request, returns just after the accepting edge (ok = 0 if the
  // engine never became ready), then scrambles the request inputs.
  task automatic drive_req(input logic [15:0][31:0] blk, input logic [7:0][31:0] st,
                           input logic use_iv, output logic ok);
    ok       = 1'b0;
    i_block  = blk;
    i_state  = st;
    i_use_iv = use_iv;
    i_valid  = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (o_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    i_valid = 1'b0;
    scramble_inputs();
  endtask

  // Cycles from the current edge until o_valid is seen; -1 on timeout.
  task automatic wait_valid(output int cycles);
    cycles = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (o_valid === 1'b1) begin
        cycles = c;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #0;
      n_checks++;
      if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_flags[%0d]: ready=%b busy=%b valid=%b expected 1 0 0", s, o_ready, o_busy, o_valid);
      end
      n_checks++;
      if (o_state !== '0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got %h expected 0", s, o_state);
      end
    end
    sel = 0;
    rst = 1'b0;
    tick();
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_fsm: got %0d expected %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_abc();
    logic ok;
    int   cyc;
    logic [255:0] exp;
    sel = 0;
    drive_req(blk_be(ABC_BLK), '0, 1'b1, ok);
    exp_q.push_back(dig_be(ABC_DIG));
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL abc_accept: engine never ready"); end
    // During the rounds: i_ready and i_valid (with garbage data) must be ignored.
    i_ready = 1'b1;
    i_valid = 1'b1;
    tick();
    n_checks++;
    if (o_ready !== 1'b0 || o_busy !== 1'b1 || dbg_state !== ST_ROUND) begin
      n_fail++;
      $display("FAIL abc_busy: ready=%b busy=%b state=%0d expected 0 1 %0d", o_ready, o_busy, dbg_state, ST_ROUND);
    end
    repeat (9) tick();
    i_ready = 1'b0;
    i_valid = 1'b0;
    wait_valid(cyc);
    if (cyc > 0) cyc = cyc + 10;
    n_checks++;
    if (cyc !== 65) begin n_fail++; $display("FAIL abc_latency: got %0d expected 65", cyc); end
    exp = exp_q.pop_front();
    n_checks++;
    if (o_state !== exp) begin n_fail++; $display("FAIL abc_digest: got %h expected %h", o_state, exp); end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abc_handshake: valid=%b ready=%b expected 0 1", o_valid, o_ready);
    end
  endtask

  task automatic test_empty_unroll();
    logic ok;
    int   cyc;
    int   lat [4] = '{65, 33, 17, 9};
    bit   hold [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [255:0] exp, after;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #0;
      drive_req(blk_be(EMPTY_BLK), '0, 1'b1, ok);
      exp_q.push_back(dig_be(EMPTY_DIG));
      wait_valid(cyc);
      n_checks++;
      if (!ok || cyc !== lat[s]) begin
        n_fail++;
        $display("FAIL empty_latency[%0d]: got %0d expected %0d", s, cyc, lat[s]);
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (o_state !== exp) begin n_fail++; $display("FAIL empty_digest[%0d]: got %h expected %h", s, o_state, exp); end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      after = hold[s] ? exp : '0;
      n_checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_state !== after) begin
        n_fail++;
        $display("FAIL empty_out_hold[%0d]: valid=%b ready=%b state=%h expected 0 1 %h", s, o_valid, o_ready, o_state, after);
      end
    end
    sel = 0;
  endtask

  task automatic test_two_block();
    logic ok;
    int   cyc;
    logic [255:0] exp;
    sel = 1;
    #0;
    drive_req(blk_be(TWO_BLK1), '0, 1'b1, ok);
    exp_q.push_back(dig_be(TWO_MID));
    wait_valid(cyc);
    n_checks++;
    if (!ok || cyc !== 33) begin n_fail++; $display("FAIL two_blk1_latency: got %0d expected 33", cyc); end
    exp = exp_q.pop_front();
    n_checks++;
    if (o_state !== exp) begin n_fail++; $display("FAIL two_blk1_digest: got %h expected %h", o_state, exp); end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    drive_req(blk_be(TWO_BLK2), dig_be(TWO_MID), 1'b0, ok);
    exp_q.push_back(dig_be(TWO_DIG));
    wait_valid(cyc);
    n_checks++;
    if (!ok || cyc !== 33) begin n_fail++; $display("FAIL two_blk2_latency: got %0d expected 33", cyc); end
    exp = exp_q.pop_front();
    n_checks++;
    if (o_state !== exp) begin n_fail++; $display("FAIL two_blk2_digest: got %h expected %h", o_state, exp); end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    sel = 0;
  endtask

  task automatic test_backpressure();
    logic ok;
    int   cyc;
    logic [255:0] exp;
    sel = 3;
    #0;
    drive_req(blk_be(ABC_BLK), '0, 1'b1, ok);
    exp_q.push_back(dig_be(ABC_DIG));
    wait_valid(cyc);
    n_checks++;
    if (!ok || cyc !== 9) begin n_fail++; $display("FAIL bp_latency: got %0d expected 9", cyc); end
    exp = exp_q.pop_front();
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        i_valid = 1'b1;
        for (int i = 0; i < 16; i++) i_block[i] = $urandom;
      end
      if (k == 6) i_valid = 1'b0;
      tick();
      n_checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_state !== exp) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b state=%h expected 1 0 %h", k, o_valid, o_ready, o_state, exp);
      end
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b ready=%b busy=%b expected 0 1 0", o_valid, o_ready, o_busy);
    end
    sel = 0;
  endtask

  task automatic test_mid_reset();
    logic ok;
    int   cyc;
    bit   seen_valid;
    logic [255:0] exp;
    sel = 0;
    drive_req(blk_be(ABC_BLK), '0, 1'b1, ok);
    exp_q.push_back(dig_be(ABC_DIG));
    repeat (20) tick();
    for (int i = 0; i < 16; i++) i_block[i] = $urandom;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_state !== '0) begin
      n_fail++;
      $display("FAIL midrst_state: ready=%b valid=%b busy=%b state=%h expected 1 0 0 0", o_ready, o_valid, o_busy, o_state);
    end
    seen_valid = 1'b0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (o_valid !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid) begin n_fail++; $display("FAIL midrst_no_valid: got valid after abort expected none"); end
    drive_req(blk_be(ABC_BLK), '0, 1'b1, ok);
    exp_q.push_back(dig_be(ABC_DIG));
    wait_valid(cyc);
    n_checks++;
    if (!ok || cyc !== 65) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 65", cyc); end
    exp = exp_q.pop_front();
    n_checks++;
    if (o_state !== exp) begin n_fail++; $display("FAIL midrst_digest: got %h expected %h", o_state, exp); end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    sel      = 0;
    rst      = 1'b1;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_use_iv = 1'b0;
    i_block  = '0;
    i_state  = '0;
    test_reset();
    test_abc();
    test_empty_unroll();
    test_two_block();
    test_backpressure();
    test_mid_reset();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_compress.md
Name: sha256_compress

Overview:
Iterative SHA-256 compression engine. Takes one 512-bit message block plus a chaining state (or the standard IV) and runs all 64 rounds with an on-chip message schedule. Applies the final feed-forward addition and returns the 256-bit result. Throughput/area is set by UNROLL (rounds per clock). Sits between the block formatter (midstate/nonce insertion) and the double-hash/target-compare stage of the miner.

Parameters:
UNROLL, 1, rounds evaluated per clock; legal values 1, 2, 4, 8; any other value is an elaboration-time error.
OUT_HOLD, 1, 1 = o_state holds its last digest after handshake; 0 = o_state clears to 0 on handshake.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
i_valid  input  1  request: block and state inputs valid
o_ready  output  1  engine can accept a request (combinational, high only in IDLE)
i_block  input  32 x [15:0]  message words; index 0 = W0 (first big-endian word)
i_state  input  32 x [7:0]  chaining state; a is LSB (index 0), h is MSB (index 7)
i_use_iv  input  1  1 = ignore i_state and use the SHA-256 IV
o_state  output  32 x [7:0]  result H0..H7; index 0 = H0
o_valid  output  1  o_state holds a completed digest
i_ready  input  1  downstream accepts o_state
o_busy  output  1  high in ROUND or FINAL

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - state = IDLE, round counter = 0, o_valid = 0, o_state = all 0, working and schedule registers = 0.
  - o_ready = 1 and o_busy = 0 from the first cycle after reset.
  - Reset during ROUND, FINAL or DONE aborts the in-flight block. No partial result is ever flagged valid.
- FSM states: IDLE, ROUND, FINAL, DONE.
  - IDLE: on i_valid && o_ready (edge t0):
    - latch the init state (IV if i_use_iv, else i_state) into both the working letters a..h and the feed-forward register.
    - latch i_block into the 16-word schedule window.
    - counter = 0; go to ROUND.
  - ROUND: each edge applies UNROLL consecutive rounds and counter += UNROLL. When the counter reaches 64 - UNROLL on that edge, go to FINAL.
  - FINAL: one edge; o_state[i] = feedforward[i] + letter[i] (mod 2^32); o_valid = 1; go to DONE.
  - DONE: hold o_state/o_valid until i_valid... no: hold until i_ready is high at an edge. On that edge o_valid = 0 and the state returns to IDLE. o_state holds or clears per OUT_HOLD.
- Latency: o_valid is high after edge t0 + 64/UNROLL + 1. This gives 65/33/17/9 cycles for UNROLL 1/2/4/8. Requests are non-overlapping; the next accept is possible on the cycle after the output handshake.
- i_valid outside IDLE is ignored (o_ready low); the requester must hold it.
- i_ready outside DONE is ignored.
- The bench checks that i_block, i_state and i_use_iv are sampled only at the accepting edge; later changes must not affect the result.
- Round t:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - new a = T1 + T2; new e = d + T1; the other letters shift.
  - All arithmetic is mod 2^32 with no carry out.
- Schedule: W[t] for t < 16 comes from the window. For t ≥ 16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16]. The window shifts by UNROLL words per ROUND edge. Word t of the current step is window index (t mod UNROLL) after the shift alignment.
- Unrolled rounds within one cycle chain combinationally; there is no pipeline register between them.

Decomposition:
- sha256_pkg:
  - K[0:63] constant array and IV[0:7] constant.
  - state enum (IDLE, ROUND, FINAL, DONE).
  - the legal-UNROLL check.
- Sub-module sha256_round: combinational single round (letters a..h, W, K in; next letters out). It is built from the existing sigma_0, sigma_1, choose and majority modules and is instantiated UNROLL times via generate.
- The schedule uses the existing sigma_shift_0/sigma_shift_1 modules.

Test Plan:
- "abc" padded block (W0 = 61626380, W15 = 00000018, others 0), i_use_iv = 1, UNROLL = 1 → o_state = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. o_valid is first high 65 cycles after accept.
- Empty message (W0 = 80000000, others 0), IV → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. Repeat for UNROLL = 2/4/8 and check latency 33/17/9.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with IV, then block 2 with i_use_iv = 0 and i_state = block-1 output → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure:
  - Hold i_ready low for 10 cycles in DONE → o_state stable, o_valid stays 1, o_ready stays 0, and a pulse on i_valid is ignored.
  - Then raise i_ready → o_valid = 0 and o_ready = 1 on the next cycle.
- Mid-operation reset:
  - Assert rst at counter = 20 and change i_block after accept → no o_valid, o_ready = 1 the cycle after reset, o_state = 0.
  - A following "abc" request still produces the correct digest.
- OUT_HOLD = 0 → o_state reads 0 on the cycle after the output handshake.
